// File: rtl/timer_pkg.sv
// Shared types, limits and helpers for the timer/counter array.
package timer_pkg;

  localparam int TC_MAX_CH = 16;
  localparam int TC_MAX_W  = 32;

  typedef enum logic [1:0] {
    TC_IDLE,
    TC_RUN,
    TC_HALT
  } tc_state_e;

  // Extracts channel idx (each slice `width` bits wide) from a vector padded to the maximum size.
  function automatic logic [TC_MAX_W-1:0] sel_slice(
    input logic [TC_MAX_CH*TC_MAX_W-1:0] vec,
    input int unsigned                   idx,
    input int unsigned                   width
  );
    logic [TC_MAX_W-1:0] mask;
    mask = {TC_MAX_W{1'b1}} >> (TC_MAX_W - width);
    return TC_MAX_W'(vec >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/HALT control FSM, counter and registered done pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_BW_p = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_reload,
  input  logic                i_count_up,
  input  logic                i_step,
  input  logic                i_load_strobe,
  input  logic [CNT_BW_p-1:0] i_load_value,
  input  logic [CNT_BW_p-1:0] i_compare_value,
  output logic [CNT_BW_p-1:0] o_cnt_value,
  output logic                o_running,
  output logic                o_done
);

  tc_state_e           state_q, state_d;
  logic [CNT_BW_p-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TC_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!i_en) begin
      // Disable wins over everything; the counter value is kept for software to read.
      state_d = TC_IDLE;
    end else if (i_load_strobe) begin
      cnt_d   = i_load_value;
      state_d = TC_RUN;
    end else begin
      unique case (state_q)
        TC_IDLE: begin
          cnt_d   = i_load_value;
          state_d = TC_RUN;
        end
        TC_RUN: begin
          if (i_step) begin
            if (cnt_q == i_compare_value) begin
              done_d = 1'b1;
              if (i_reload) cnt_d = i_load_value;
              else          state_d = TC_HALT;
            end else if (i_count_up) begin
              cnt_d = cnt_q + CNT_BW_p'(1);
            end else begin
              cnt_d = cnt_q - CNT_BW_p'(1);
            end
          end
        end
        TC_HALT: ;
        default: state_d = TC_IDLE;
      endcase
    end
  end

  assign o_cnt_value = cnt_q;
  assign o_running   = (state_q == TC_RUN);
  assign o_done      = done_q;

endmodule

// File: rtl/timer_counter_array.sv
// N-channel timer/counter: shared prescaler, cascade step mux, channel array and sticky IRQ flags.
module timer_counter_array
  import timer_pkg::*;
#(
  parameter int NUM_CH_p   = 4,
  parameter int CNT_BW_p   = 32,
  parameter int PRESC_BW_p = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PRESC_BW_p-1:0]        i_presc_div,
  input  logic [NUM_CH_p-1:0]          i_en,
  input  logic [NUM_CH_p-1:0]          i_reload,
  input  logic [NUM_CH_p-1:0]          i_count_up,
  input  logic [NUM_CH_p-1:0]          i_src,
  input  logic [NUM_CH_p-1:0]          i_load_strobe,
  input  logic [NUM_CH_p*CNT_BW_p-1:0] i_load_value,
  input  logic [NUM_CH_p*CNT_BW_p-1:0] i_compare_value,
  input  logic [NUM_CH_p-1:0]          i_irq_en,
  input  logic [NUM_CH_p-1:0]          i_irq_clr,
  output logic [NUM_CH_p*CNT_BW_p-1:0] o_cnt_value,
  output logic [NUM_CH_p-1:0]          o_running,
  output logic [NUM_CH_p-1:0]          o_done,
  output logic [NUM_CH_p-1:0]          o_irq_pending,
  output logic                         o_irq
);

  logic [PRESC_BW_p-1:0]           presc_cnt;
  logic                            tick;
  logic [NUM_CH_p-1:0]             done;
  logic [NUM_CH_p-1:0]             prev_done;
  logic [NUM_CH_p-1:0]             src_eff;
  logic [NUM_CH_p-1:0]             step;
  logic [NUM_CH_p-1:0]             irq_pending;
  logic [TC_MAX_CH*TC_MAX_W-1:0]   load_pad;
  logic [TC_MAX_CH*TC_MAX_W-1:0]   cmp_pad;

  // >= rather than == so lowering the divider mid-count never strands the prescaler above it.
  assign tick = (presc_cnt >= i_presc_div);

  always_ff @(posedge clk) begin
    if (!rst_n)            presc_cnt <= '0;
    else if (!(|i_en))     presc_cnt <= '0;
    else if (tick)         presc_cnt <= '0;
    else                   presc_cnt <= presc_cnt + PRESC_BW_p'(1);
  end

  // Channel 0 has no predecessor, so its source select is forced to the prescaler.
  assign src_eff   = i_src & ~NUM_CH_p'(1);
  assign prev_done = done << 1;
  assign step      = (src_eff & prev_done) | (~src_eff & {NUM_CH_p{tick}});

  assign load_pad = (TC_MAX_CH*TC_MAX_W)'(i_load_value);
  assign cmp_pad  = (TC_MAX_CH*TC_MAX_W)'(i_compare_value);

  for (genvar n = 0; n < NUM_CH_p; n++) begin : g_ch
    logic [CNT_BW_p-1:0] ld_val;
    logic [CNT_BW_p-1:0] cmp_val;

    assign ld_val  = CNT_BW_p'(sel_slice(load_pad, n, CNT_BW_p));
    assign cmp_val = CNT_BW_p'(sel_slice(cmp_pad, n, CNT_BW_p));

    timer_channel #(
      .CNT_BW_p (CNT_BW_p)
    ) u_channel (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_en            (i_en[n]),
      .i_reload        (i_reload[n]),
      .i_count_up      (i_count_up[n]),
      .i_step          (step[n]),
      .i_load_strobe   (i_load_strobe[n]),
      .i_load_value    (ld_val),
      .i_compare_value (cmp_val),
      .o_cnt_value     (o_cnt_value[n*CNT_BW_p +: CNT_BW_p]),
      .o_running       (o_running[n]),
      .o_done          (done[n])
    );
  end

  // A new done event outranks a clear arriving in the same cycle so no event is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) irq_pending <= '0;
    else        irq_pending <= (irq_pending & ~i_irq_clr) | done;
  end

  assign o_done        = done;
  assign o_irq_pending = irq_pending;
  assign o_irq         = |(irq_pending & i_irq_en);

endmodule

// File: tb/tb_timer_counter_array.sv
// Directed self-checking bench for timer_counter_array (4 channels, 32-bit, 8-bit prescaler).
module tb_timer_counter_array;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int PW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PW-1:0]     presc_div;
  logic [NCH-1:0]    en, reload, count_up, src, load_strobe, irq_en, irq_clr;
  logic [NCH*W-1:0]  load_value, compare_value;
  logic [NCH*W-1:0]  cnt_value;
  logic [NCH-1:0]    running, done, irq_pending;
  logic              irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  timer_counter_array #(
    .NUM_CH_p   (NCH),
    .CNT_BW_p   (W),
    .PRESC_BW_p (PW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_presc_div     (presc_div),
    .i_en            (en),
    .i_reload        (reload),
    .i_count_up      (count_up),
    .i_src           (src),
    .i_load_strobe   (load_strobe),
    .i_load_value    (load_value),
    .i_compare_value (compare_value),
    .i_irq_en        (irq_en),
    .i_irq_clr       (irq_clr),
    .o_cnt_value     (cnt_value),
    .o_running       (running),
    .o_done          (done),
    .o_irq_pending   (irq_pending),
    .o_irq           (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] cnt_of(input int ch);
    return cnt_value[ch*W +: W];
  endfunction

  // One clock edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input logic [W-1:0] ld, input logic [W-1:0] cmp,
                     input logic up, input logic rl, input logic sr);
    load_value[ch*W +: W]    = ld;
    compare_value[ch*W +: W] = cmp;
    count_up[ch] = up;
    reload[ch]   = rl;
    src[ch]      = sr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    presc_div = '0; en = '0; reload = '0; count_up = '0; src = '0;
    load_strobe = '0; irq_en = '0; irq_clr = '0;
    load_value = '0; compare_value = '0;
    step_clk();
    rst_n = 1'b1;
  endtask

  initial begin
    int first_done;
    int n_done;

    do_reset();
    check("reset_cnt",     64'(cnt_value), 64'd0);
    check("reset_running", 64'(running), 64'd0);
    check("reset_done",    64'(done), 64'd0);
    check("reset_pending", 64'(irq_pending), 64'd0);
    check("reset_irq",     64'(irq), 64'd0);

    // 1: ch0 up, auto-reload, 0..3, tick every clock.
    cfg(0, 32'd0, 32'd3, 1'b1, 1'b1, 1'b0);
    en[0] = 1'b1;
    step_clk();
    check("t1_load_cnt", 64'(cnt_of(0)), 64'd0);
    check("t1_running",  64'(running[0]), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      step_clk();
      check($sformatf("t1_cnt_e%0d", k), 64'(cnt_of(0)), 64'(k % 4));
      check($sformatf("t1_done_e%0d", k), 64'(done[0]), 64'((k % 4) == 0));
    end

    // 2: ch1 down, one-shot 5->0, divider 2: done only after the 18th edge.
    do_reset();
    presc_div = 8'd2;
    cfg(1, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    en[1] = 1'b1;
    first_done = -1;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      step_clk();
      if (done[1]) begin
        n_done++;
        if (first_done < 0) first_done = k + 1;
      end
    end
    check("t2_first_done_edges", 64'(first_done), 64'd18);
    check("t2_done_count",       64'(n_done), 64'd1);
    check("t2_running",          64'(running[1]), 64'd0);
    check("t2_cnt_hold",         64'(cnt_of(1)), 64'd0);

    // 3: ch2 up across the 2^32 wrap, one-shot.
    do_reset();
    cfg(2, 32'hFFFF_FFFE, 32'd1, 1'b1, 1'b0, 1'b0);
    en[2] = 1'b1;
    begin
      logic [W-1:0] exp_cnt [5];
      exp_cnt[0] = 32'hFFFF_FFFE; exp_cnt[1] = 32'hFFFF_FFFF;
      exp_cnt[2] = 32'd0; exp_cnt[3] = 32'd1; exp_cnt[4] = 32'd1;
      for (int k = 0; k < 5; k++) begin
        step_clk();
        check($sformatf("t3_cnt_e%0d", k), 64'(cnt_of(2)), 64'(exp_cnt[k]));
        check($sformatf("t3_done_e%0d", k), 64'(done[2]), 64'(k == 4));
      end
    end
    check("t3_halted", 64'(running[2]), 64'd0);

    // 4: cascade; ch1 counts ch0 done events, done one clock after every 2nd ch0 done.
    do_reset();
    cfg(0, 32'd0, 32'd3, 1'b1, 1'b1, 1'b0);
    cfg(1, 32'd0, 32'd1, 1'b1, 1'b1, 1'b1);
    en[1:0] = 2'b11;
    for (int k = 0; k <= 20; k++) begin
      logic [1:0] exp_d;
      step_clk();
      exp_d[0] = (k > 0) && (k % 4 == 0);
      exp_d[1] = (k > 1) && (k % 8 == 1);
      check($sformatf("t4_done_e%0d", k), 64'(done[1:0]), 64'(exp_d));
    end

    // 5: sticky IRQ, set beats clear, clear alone, mask.
    do_reset();
    cfg(0, 32'd0, 32'd3, 1'b1, 1'b1, 1'b0);
    irq_en[0] = 1'b1;
    en[0] = 1'b1;
    for (int k = 0; k <= 4; k++) step_clk();
    check("t5_done_e4",   64'(done[0]), 64'd1);
    check("t5_pend_e4",   64'(irq_pending[0]), 64'd0);
    step_clk();
    check("t5_pend_set",  64'(irq_pending[0]), 64'd1);
    check("t5_irq_set",   64'(irq), 64'd1);
    for (int k = 6; k <= 8; k++) step_clk();
    check("t5_done_e8",   64'(done[0]), 64'd1);
    irq_clr[0] = 1'b1;
    step_clk();
    check("t5_set_wins",  64'(irq_pending[0]), 64'd1);
    check("t5_irq_hold",  64'(irq), 64'd1);
    step_clk();
    check("t5_clr",       64'(irq_pending[0]), 64'd0);
    check("t5_irq_clr",   64'(irq), 64'd0);
    irq_clr[0] = 1'b0;
    for (int k = 11; k <= 13; k++) step_clk();
    check("t5_pend_again", 64'(irq_pending[0]), 64'd1);
    irq_en[0] = 1'b0;
    #1;
    check("t5_irq_masked", 64'(irq), 64'd0);

    // 6a: enable dropped at cnt=2 -> IDLE, value retained.
    do_reset();
    cfg(0, 32'd0, 32'd3, 1'b1, 1'b1, 1'b0);
    en[0] = 1'b1;
    for (int k = 0; k <= 2; k++) step_clk();
    check("t6_cnt_before_drop", 64'(cnt_of(0)), 64'd2);
    en[0] = 1'b0;
    step_clk();
    check("t6_idle_running", 64'(running[0]), 64'd0);
    step_clk();
    step_clk();
    check("t6_idle_cnt_hold", 64'(cnt_of(0)), 64'd2);

    // 6b: one-shot halts, then a load strobe restarts from the new load value.
    do_reset();
    cfg(0, 32'd0, 32'd1, 1'b1, 1'b0, 1'b0);
    irq_en[0] = 1'b1;
    en[0] = 1'b1;
    for (int k = 0; k <= 2; k++) step_clk();
    check("t6_halt_done", 64'(done[0]), 64'd1);
    step_clk();
    step_clk();
    check("t6_halt_running", 64'(running[0]), 64'd0);
    check("t6_halt_cnt",     64'(cnt_of(0)), 64'd1);
    cfg(0, 32'd7, 32'd9, 1'b1, 1'b0, 1'b0);
    load_strobe[0] = 1'b1;
    step_clk();
    load_strobe[0] = 1'b0;
    check("t6_strobe_running", 64'(running[0]), 64'd1);
    check("t6_strobe_cnt",     64'(cnt_of(0)), 64'd7);
    step_clk();
    check("t6_strobe_count",   64'(cnt_of(0)), 64'd8);
    check("t6_irq_before_rst", 64'(irq), 64'd1);

    // 6c: one reset cycle mid-count clears everything.
    rst_n = 1'b0;
    step_clk();
    check("t6_rst_cnt",     64'(cnt_value), 64'd0);
    check("t6_rst_running", 64'(running), 64'd0);
    check("t6_rst_done",    64'(done), 64'd0);
    check("t6_rst_pending", 64'(irq_pending), 64'd0);
    check("t6_rst_irq",     64'(irq), 64'd0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
